sum_accumulator: RTL and testbench
==================================

Name: sum_accumulator

Overview:
- Downstream consumer of the 6-bit ripple-carry adder (Carry_adder).
- Takes each adder result (sum, c_out, overflow) under a valid/ready handshake.
- Rebuilds the exact 7-bit result, then accumulates COUNT results into a wider register.
- Presents the block total on an output handshake. Used by the arithmetic datapath to build dot-products and running totals.

Parameters:
- DATA_W, 6: adder result width (sum width).
- ACC_W, 16: accumulator/output width; must be at least DATA_W+1.
- COUNT, 8: samples per block; must be at least 1.
- SIGNED, 1: 1 means two's-complement operands, 0 means unsigned.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- clr  in  1  synchronous clear of the block in progress.
- in_valid  in  1  adder result valid.
- in_ready  out  1  block accepts a result this cycle.
- sum  in  DATA_W  adder sum.
- c_out  in  1  adder carry out.
- overflow  in  1  adder signed overflow.
- out_valid  out  1  block total valid.
- out_ready  in  1  downstream accepts the total.
- acc_out  out  ACC_W  block total.
- out_sat  out  1  sticky accumulator-range flag for the current block.
- busy  out  1  at least one sample accepted in the current block.

Behaviour:
- Interface: one clock (clk); synchronous active-low reset (rst_n).
- Reset (rst_n=0 at a clk edge): state=ACC, acc=0, cnt=0, out_valid=0, out_sat=0, busy=0. in_ready=1 from the first cycle after reset.
- Extension to ACC_W bits:
  - SIGNED=1: e = overflow ? {~sum[DATA_W-1], sum} : {sum[DATA_W-1], sum}, then sign-extended. This is the true 7-bit sum.
  - SIGNED=0: e = {c_out, sum}, zero-extended.
- FSM, two states:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1; acc_out and out_sat held stable.
- Accept condition: in_valid && in_ready.
  - On accept: acc <= acc + e (with range handling below), cnt++, busy=1.
  - If cnt==COUNT-1 on the accept: go to DONE and reset cnt to 0.
  - Latency: out_valid rises the cycle after the final sample is accepted, with acc_out final in that same cycle.
- In DONE, on out_ready=1: next cycle acc=0, out_sat=0, busy=0, state=ACC. The first new sample is accepted no earlier than that cycle (no bypass).
- In DONE with out_ready=0: hold indefinitely. in_valid is ignored (in_ready=0); the upstream adder must hold its data.
- Range handling: compute the ACC_W+1-bit sum. If it falls outside the ACC_W range (signed or unsigned per SIGNED), set out_sat=1 (sticky until the block is consumed). The stored value depends on the optional feature.
- clr=1: in any state, next cycle acc=0, cnt=0, out_sat=0, busy=0, state=ACC.
  - clr beats a simultaneous accept and a simultaneous out_ready.
  - A pending DONE result is discarded.
- rst_n beats clr.
- COUNT=1: every accepted sample goes straight to DONE.
- acc_out always drives the acc register. Its value is architecturally meaningful only while out_valid=1.

Optional Feature:
- Macro: SUM_ACCUMULATOR_SAT_EN.
- Defined: on range exit, acc clamps to the maximum or minimum of ACC_W (signed: 2^(ACC_W-1)-1 / -2^(ACC_W-1); unsigned: 2^ACC_W-1 / 0). Saturation holds for later samples in the same direction.
- Undefined: acc wraps modulo 2^ACC_W.
- out_sat is set identically in both builds.

Decomposition:
- Shared package (adder_pkg): DATA_W default, state enum {ST_ACC, ST_DONE}, extension function ext_sum(sum, c_out, overflow, signed_mode).
- One natural sub-module: sum_extend. Combinational DATA_W to DATA_W+1 reconstruction, reusable by other consumers of Carry_adder.
- FSM, counter and accumulator stay in the top module.

Test Plan:
- COUNT=4, ACC_W=16, SIGNED=1: four samples sum=3, ovf=0 -> out_valid one cycle after the 4th accept, acc_out=12, out_sat=0.
- Four samples of the adder result for 31+31 (sum=6'b111110, overflow=1) -> each e=62; acc_out=248, out_sat=0.
- Four samples of the result for -32+-32 (sum=0, overflow=1) -> each e=-64; acc_out=-256. Then SIGNED=0 with sum=6'h3F, c_out=1 x4 -> acc_out=508.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 -> out_valid stays 1, acc_out stays 12, in_ready=0, no sample counted. The next block sums correctly after out_ready=1.
- ACC_W=8, four samples e=62: with SUM_ACCUMULATOR_SAT_EN -> acc_out=127, out_sat=1. Without -> acc_out=-8 (248 mod 256), out_sat=1.
- clr asserted after 2 accepts and coincident with a 3rd in_valid -> sample dropped, busy=0. The next 4 samples (sum=1) give acc_out=4. rst_n=0 in DONE -> out_valid=0 next cycle.

Source files
------------

// File: rtl/sum_accumulator_pkg.sv
// Shared types and helpers for consumers of the 6-bit ripple-carry adder.
// Holds the FSM state enum and the 7-bit result reconstruction function.
package adder_pkg;

    localparam int DATA_W_DEF = 6;

    typedef enum logic {
        ST_ACC,
        ST_DONE
    } state_e;

    // Rebuilds the exact DATA_W_DEF+1 bit result from sum/carry/overflow.
    function automatic logic [DATA_W_DEF:0] ext_sum(
        input logic [DATA_W_DEF-1:0] sum,
        input logic                  c_out,
        input logic                  overflow,
        input logic                  signed_mode
    );
        logic [DATA_W_DEF:0] r;
        if (signed_mode) begin
            if (overflow) begin
                r = {~sum[DATA_W_DEF-1], sum};
            end else begin
                r = {sum[DATA_W_DEF-1], sum};
            end
        end else begin
            r = {c_out, sum};
        end
        return r;
    endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Input and output handshakes of the adder-result accumulator.
// master drives samples and consumes totals; slave is the accumulator.
interface sum_accumulator_if #(
    parameter int DATA_W = 6,
    parameter int ACC_W  = 16
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] sum;
    logic              c_out;
    logic              overflow;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              out_sat;

    modport master (
        output in_valid,
        output sum,
        output c_out,
        output overflow,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  acc_out,
        input  out_sat
    );

    modport slave (
        input  in_valid,
        input  sum,
        input  c_out,
        input  overflow,
        input  out_ready,
        output in_ready,
        output out_valid,
        output acc_out,
        output out_sat
    );

endinterface

// File: rtl/sum_accumulator_sum_extend.sv
// Combinational DATA_W to DATA_W+1 reconstruction of an adder result.
// Reusable by any consumer of the ripple-carry adder.
module sum_extend
    import adder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SIGNED = 1
) (
    input  logic [DATA_W-1:0] sum_i,
    input  logic              c_out_i,
    input  logic              overflow_i,
    output logic [DATA_W:0]   ext_o
);

    if (DATA_W == DATA_W_DEF) begin : g_pkg
        assign ext_o = ext_sum(sum_i, c_out_i, overflow_i, SIGNED != 0);
    end else begin : g_gen
        always_comb begin
            ext_o = {c_out_i, sum_i};
            if (SIGNED != 0) begin
                // overflow means the sign bit of sum is the wrong one
                if (overflow_i) begin
                    ext_o = {~sum_i[DATA_W-1], sum_i};
                end else begin
                    ext_o = {sum_i[DATA_W-1], sum_i};
                end
            end
        end
    end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates COUNT reconstructed adder results into an ACC_W block total.
// Define SUM_ACCUMULATOR_SAT_EN to clamp on range exit instead of wrapping.
module sum_accumulator
    import adder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 8,
    parameter int SIGNED = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    sum_accumulator_if.slave   bus,
    output logic               busy
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               busy_q, busy_d;

    logic [DATA_W:0]    ext;
    logic [ACC_W:0]     e_x;
    logic [ACC_W:0]     a_x;
    logic [ACC_W:0]     s_x;
    logic               rng;
    logic [ACC_W-1:0]   acc_nx;
    logic               in_ready;
    logic               out_valid;
    logic               accept;

    sum_extend #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_ext (
        .sum_i      (bus.sum),
        .c_out_i    (bus.c_out),
        .overflow_i (bus.overflow),
        .ext_o      (ext)
    );

    // One extra bit holds any acc + e exactly.
    always_comb begin
        if (SIGNED != 0) begin
            e_x = {{(ACC_W - DATA_W){ext[DATA_W]}}, ext};
            a_x = {acc_q[ACC_W-1], acc_q};
            s_x = a_x + e_x;
            rng = s_x[ACC_W] ^ s_x[ACC_W-1];
        end else begin
            e_x = {{(ACC_W - DATA_W){1'b0}}, ext};
            a_x = {1'b0, acc_q};
            s_x = a_x + e_x;
            rng = s_x[ACC_W];
        end
    end

`ifdef SUM_ACCUMULATOR_SAT_EN
    logic [ACC_W-1:0] sat_val;

    always_comb begin
        if (SIGNED != 0) begin
            sat_val = s_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat_val = {ACC_W{1'b1}};
        end
        acc_nx = rng ? sat_val : s_x[ACC_W-1:0];
    end
`else
    assign acc_nx = s_x[ACC_W-1:0];
`endif

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        busy_d  = busy_q;
        if (clr) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        acc_d  = acc_nx;
                        sat_d  = sat_q | rng;
                        busy_d = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        acc_d   = '0;
                        sat_d   = 1'b0;
                        busy_d  = 1'b0;
                        state_d = ST_ACC;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.acc_out   = acc_q;
    assign bus.out_sat   = sat_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three instances share one stimulus stream.
// A: 16-bit signed, B: 16-bit unsigned, C: 8-bit signed; COUNT=4 for all.
module tb_sum_accumulator;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [5:0] sum;
    logic       c_out;
    logic       overflow;
    logic       out_ready;
    logic       busy_a, busy_b, busy_c;

    int total = 0;
    int bad   = 0;

    sum_accumulator_if #(.DATA_W(6), .ACC_W(16)) ifa ();
    sum_accumulator_if #(.DATA_W(6), .ACC_W(16)) ifb ();
    sum_accumulator_if #(.DATA_W(6), .ACC_W(8))  ifc ();

    assign ifa.in_valid = in_valid;
    assign ifa.sum = sum;
    assign ifa.c_out = c_out;
    assign ifa.overflow = overflow;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid = in_valid;
    assign ifb.sum = sum;
    assign ifb.c_out = c_out;
    assign ifb.overflow = overflow;
    assign ifb.out_ready = out_ready;
    assign ifc.in_valid = in_valid;
    assign ifc.sum = sum;
    assign ifc.c_out = c_out;
    assign ifc.overflow = overflow;
    assign ifc.out_ready = out_ready;

    sum_accumulator #(.DATA_W(6), .ACC_W(16), .COUNT(4), .SIGNED(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifa.slave), .busy(busy_a)
    );
    sum_accumulator #(.DATA_W(6), .ACC_W(16), .COUNT(4), .SIGNED(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifb.slave), .busy(busy_b)
    );
    sum_accumulator #(.DATA_W(6), .ACC_W(8), .COUNT(4), .SIGNED(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifc.slave), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint acc [3];
        bit     sat [3];
    } exp_t;

    exp_t   sbq [$];
    int     accw [3] = '{16, 16, 8};
    bit     sgn  [3] = '{1'b1, 1'b0, 1'b1};
    longint macc [3];
    bit     msat [3];
    bit     mst;
    int     mcnt;
    bit     mbusy;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint ext_model(bit sg, logic [5:0] s, logic co,
                                         logic ov);
        longint u;
        u = longint'(s);
        if (sg) begin
            if (ov) return s[5] ? u : u - 64;
            return s[5] ? u - 64 : u;
        end
        return co ? u + 64 : u;
    endfunction

    function automatic logic [31:0] bits(longint v, int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return 32'(v & m);
    endfunction

    task automatic upd(int k);
        longint v, lo, hi, m;
        m  = longint'(1) << accw[k];
        lo = sgn[k] ? -(m / 2) : 0;
        hi = sgn[k] ? (m / 2) - 1 : m - 1;
        v  = macc[k] + ext_model(sgn[k], sum, c_out, overflow);
        if (v < lo || v > hi) begin
            msat[k] = 1'b1;
`ifdef SUM_ACCUMULATOR_SAT_EN
            v = (v > hi) ? hi : lo;
`else
            v = (((v - lo) % m) + m) % m + lo;
`endif
        end
        macc[k] = v;
    endtask

    task automatic model_edge();
        exp_t e;
        if (!rst_n || clr) begin
            mst = 1'b0;
            mcnt = 0;
            mbusy = 1'b0;
            for (int k = 0; k < 3; k++) begin
                macc[k] = 0;
                msat[k] = 1'b0;
            end
            sbq.delete();
        end else if (!mst && in_valid) begin
            for (int k = 0; k < 3; k++) upd(k);
            mbusy = 1'b1;
            if (mcnt == 3) begin
                mcnt = 0;
                mst = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    e.acc[k] = macc[k];
                    e.sat[k] = msat[k];
                end
                sbq.push_back(e);
            end else begin
                mcnt++;
            end
        end else if (mst && out_ready) begin
            if (sbq.size() > 0) void'(sbq.pop_front());
            mst = 1'b0;
            mbusy = 1'b0;
            for (int k = 0; k < 3; k++) begin
                macc[k] = 0;
                msat[k] = 1'b0;
            end
        end
    endtask

    task automatic compare();
        exp_t e;
        chk("a_in_ready", 32'(ifa.in_ready), 32'(!mst));
        chk("b_in_ready", 32'(ifb.in_ready), 32'(!mst));
        chk("c_in_ready", 32'(ifc.in_ready), 32'(!mst));
        chk("a_out_valid", 32'(ifa.out_valid), 32'(mst));
        chk("b_out_valid", 32'(ifb.out_valid), 32'(mst));
        chk("c_out_valid", 32'(ifc.out_valid), 32'(mst));
        chk("a_busy", 32'(busy_a), 32'(mbusy));
        chk("b_busy", 32'(busy_b), 32'(mbusy));
        chk("c_busy", 32'(busy_c), 32'(mbusy));
        if (mst && sbq.size() > 0) begin
            e = sbq[0];
            chk("a_acc", 32'(ifa.acc_out), bits(e.acc[0], 16));
            chk("b_acc", 32'(ifb.acc_out), bits(e.acc[1], 16));
            chk("c_acc", 32'(ifc.acc_out), bits(e.acc[2], 8));
            chk("a_sat", 32'(ifa.out_sat), 32'(e.sat[0]));
            chk("b_sat", 32'(ifb.out_sat), 32'(e.sat[1]));
            chk("c_sat", 32'(ifc.out_sat), 32'(e.sat[2]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic set_in(logic v, logic [5:0] s, logic co, logic ov);
        in_valid = v;
        sum = s;
        c_out = co;
        overflow = ov;
    endtask

    task automatic block(logic [5:0] s, logic co, logic ov);
        set_in(1'b1, s, co, ov);
        repeat (4) tick();
        set_in(1'b0, 6'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 6'd0, 1'b0, 1'b0);
        mst = 1'b0;
        mcnt = 0;
        mbusy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            macc[k] = 0;
            msat[k] = 1'b0;
        end
        #2;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // sum=3 x4, then backpressure with new data offered
        set_in(1'b1, 6'd3, 1'b0, 1'b0);
        repeat (4) tick();
        set_in(1'b1, 6'd7, 1'b0, 1'b0);
        repeat (5) tick();
        set_in(1'b0, 6'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        block(6'b111110, 1'b0, 1'b1);
        block(6'd0, 1'b1, 1'b1);
        block(6'h3F, 1'b1, 1'b0);

        // clr coincident with a third valid sample
        set_in(1'b1, 6'd5, 1'b0, 1'b0);
        repeat (2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_in(1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        block(6'd1, 1'b0, 1'b0);

        // clr beats out_ready in DONE
        set_in(1'b1, 6'd2, 1'b0, 1'b0);
        repeat (4) tick();
        set_in(1'b0, 6'd0, 1'b0, 1'b0);
        clr = 1'b1;
        out_ready = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b0;
        tick();

        // reset while DONE
        set_in(1'b1, 6'd9, 1'b0, 1'b0);
        repeat (4) tick();
        set_in(1'b0, 6'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        block(6'd1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
